// File: rtl/serial_instr_loader_if.sv
// rtl/serial_instr_loader_if.sv - load/fetch bundle between the serial loader and its user
interface serial_instr_loader_if #(
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 16
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  load_start;
   logic                  instr_in;
   logic                  instr_in_en;
   logic [AW-1:0]         rd_addr;
   logic [INST_WIDTH-1:0] instr_out;
   logic                  word_wr;
   logic [CW-1:0]         word_count;
   logic                  load_done;
   logic                  parity_err;

   modport master (
      output load_start, instr_in, instr_in_en, rd_addr,
      input  instr_out, word_wr, word_count, load_done, parity_err
   );

   modport slave (
      input  load_start, instr_in, instr_in_en, rd_addr,
      output instr_out, word_wr, word_count, load_done, parity_err
   );
endinterface

// File: rtl/serial_instr_loader.sv
// rtl/serial_instr_loader.sv - serial MSB-first instruction loader into a DEPTH-word store; optional PARITY_CHECK_EN
module serial_instr_loader #(
   parameter int INST_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset,
   serial_instr_loader_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
`ifdef PARITY_CHECK_EN
   // Data bits plus one trailing even-parity bit; shreg holds the full word
   // by the time the parity bit arrives.
   localparam int FRAME = INST_WIDTH + 1;
   localparam int SW    = INST_WIDTH;
`else
   // The final data bit is taken straight from instr_in on the commit edge,
   // so only INST_WIDTH-1 bits ever need to be held.
   localparam int FRAME = INST_WIDTH;
   localparam int SW    = INST_WIDTH - 1;
`endif
   localparam int BW = $clog2(FRAME);

   localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME - 1);
   localparam logic [CW-1:0] LAST_WORD  = CW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_ADDR = (AW + 1)'(DEPTH);

   logic [INST_WIDTH-1:0] mem [DEPTH];

   logic [BW-1:0]         bit_cnt;
   logic [SW-1:0]         shreg;
   logic [CW-1:0]         word_count;
   logic                  load_done;
   logic                  word_wr;
   logic [INST_WIDTH-1:0] instr_out_q;
   logic                  parity_err_q;

   logic                  accept;
   logic                  last_bit;
   logic                  frame_end;
   logic                  parity_ok;
   logic                  commit;
   logic                  shift_en;
   logic                  rd_in_range;
   logic [INST_WIDTH-1:0] commit_word;

   // Decode which edge accepts a bit, ends a frame, and actually commits.
   always_comb begin
      accept      = bus.instr_in_en && !load_done && !bus.load_start;
      last_bit    = (bit_cnt == LAST_BIT);
      frame_end   = accept && last_bit;
`ifdef PARITY_CHECK_EN
      commit_word = shreg;
      parity_ok   = ~^{shreg, bus.instr_in};
      shift_en    = accept && !last_bit;
`else
      commit_word = {shreg, bus.instr_in};
      parity_ok   = 1'b1;
      shift_en    = accept;
`endif
      commit      = frame_end && parity_ok;
      rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_ADDR);
   end

   // Bit/word counters, fill flag and the one-cycle commit pulse.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         bit_cnt    <= '0;
         word_count <= '0;
         load_done  <= 1'b0;
         word_wr    <= 1'b0;
      end else begin
         word_wr <= commit;
         if (bus.load_start) begin
            bit_cnt    <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
         end else if (accept) begin
            if (last_bit) begin
               bit_cnt <= '0;
               if (commit) begin
                  word_count <= word_count + 1'b1;
                  load_done  <= (word_count == LAST_WORD);
               end
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   // Serial shift register, MSB first; the oldest bit falls off the top.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= SW'({shreg, bus.instr_in});
      end
   end

`ifdef PARITY_CHECK_EN
   // Sticky parity error: set by any bad frame, cleared only by restart.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         parity_err_q <= 1'b0;
      end else if (bus.load_start) begin
         parity_err_q <= 1'b0;
      end else if (frame_end && !parity_ok) begin
         parity_err_q <= 1'b1;
      end
   end
`else
   assign parity_err_q = 1'b0;
`endif

   // Instruction store write port; contents deliberately survive reset.
   always_ff @(posedge sys_clk) begin
      if (commit) begin
         mem[word_count[AW-1:0]] <= commit_word;
      end
   end

   // Registered fetch port; same-edge writes are not forwarded.
   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         instr_out_q <= '0;
      end else if (rd_in_range) begin
         instr_out_q <= mem[bus.rd_addr];
      end else begin
         instr_out_q <= '0;
      end
   end

   assign bus.instr_out  = instr_out_q;
   assign bus.word_wr    = word_wr;
   assign bus.word_count = word_count;
   assign bus.load_done  = load_done;
   assign bus.parity_err = parity_err_q;
endmodule

// File: tb/tb_serial_instr_loader.sv
// tb/tb_serial_instr_loader.sv - directed bench for serial_instr_loader (DEPTH=4)
module tb_serial_instr_loader;
   localparam int W = 32;
   localparam int D = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;
   int   wr_pulses;
   logic [W-1:0] rd;
   int   p0;

   serial_instr_loader_if #(.INST_WIDTH(W), .DEPTH(D)) bus ();

   serial_instr_loader #(.INST_WIDTH(W), .DEPTH(D)) dut (
      .sys_clk   (clk),
      .sys_reset (rst_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.word_wr === 1'b1) wr_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.instr_in    = b;
      bus.instr_in_en = 1'b1;
      tick();
      bus.instr_in_en = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] w, input logic bad_parity);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
      send_bit((^w) ^ bad_parity);
`else
      if (bad_parity) bus.instr_in = 1'b0;
`endif
   endtask

   task automatic read_addr(input logic [1:0] a, output logic [W-1:0] data);
      bus.rd_addr = a;
      tick();
      data = bus.instr_out;
   endtask

   task automatic restart();
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++; if (bus.word_count !== 3'd0) begin fails++; $display("FAIL reset_word_count got %0d exp 0", bus.word_count); end
      checks++; if (bus.load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done got %b exp 0", bus.load_done); end
      checks++; if (bus.word_wr !== 1'b0) begin fails++; $display("FAIL reset_word_wr got %b exp 0", bus.word_wr); end
      checks++; if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err got %b exp 0", bus.parity_err); end
      checks++; if (bus.instr_out !== 32'h0) begin fails++; $display("FAIL reset_instr_out got %h exp 0", bus.instr_out); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_word();
      p0 = wr_pulses;
      bus.rd_addr = 2'd0;
      send_frame(32'hABCD_1234, 1'b0);
      checks++; if (bus.word_wr !== 1'b1) begin fails++; $display("FAIL single_word_wr got %b exp 1", bus.word_wr); end
      checks++; if (bus.word_count !== 3'd1) begin fails++; $display("FAIL single_word_count got %0d exp 1", bus.word_count); end
      tick();
      checks++; if (bus.word_wr !== 1'b0) begin fails++; $display("FAIL single_word_wr_pulse got %b exp 0", bus.word_wr); end
      checks++; if (bus.instr_out !== 32'hABCD_1234) begin fails++; $display("FAIL single_instr_out got %h exp abcd1234", bus.instr_out); end
      checks++; if (wr_pulses - p0 !== 1) begin fails++; $display("FAIL single_pulses got %0d exp 1", wr_pulses - p0); end
   endtask

   task automatic test_gap();
      logic [W-1:0] w;
      w = 32'h0F0F_A5A5;
      for (int i = W - 1; i >= 0; i--) begin
         send_bit(w[i]);
         if (i == W - 10) begin
            bus.instr_in = ~w[i - 1];
            tick(); tick(); tick();
         end
      end
`ifdef PARITY_CHECK_EN
      send_bit(^w);
`endif
      checks++; if (bus.word_count !== 3'd2) begin fails++; $display("FAIL gap_word_count got %0d exp 2", bus.word_count); end
      read_addr(2'd1, rd);
      checks++; if (rd !== 32'h0F0F_A5A5) begin fails++; $display("FAIL gap_mem1 got %h exp 0f0fa5a5", rd); end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 16; i++) send_bit(i[0]);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(32'h1234_5678, 1'b0);
      checks++; if (bus.word_count !== 3'd1) begin fails++; $display("FAIL midreset_word_count got %0d exp 1", bus.word_count); end
      read_addr(2'd0, rd);
      checks++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL midreset_mem0 got %h exp 12345678", rd); end
      read_addr(2'd1, rd);
      checks++; if (rd !== 32'h0F0F_A5A5) begin fails++; $display("FAIL midreset_mem1_kept got %h exp 0f0fa5a5", rd); end
   endtask

   task automatic test_fill();
      restart();
      p0 = wr_pulses;
      send_frame(32'hA0A0_0001, 1'b0);
      send_frame(32'hB0B0_0002, 1'b0);
      send_frame(32'hC0C0_0003, 1'b0);
      checks++; if (bus.load_done !== 1'b0) begin fails++; $display("FAIL fill3_load_done got %b exp 0", bus.load_done); end
      send_frame(32'hD0D0_0004, 1'b0);
      checks++; if (bus.load_done !== 1'b1) begin fails++; $display("FAIL fill4_load_done got %b exp 1", bus.load_done); end
      checks++; if (bus.word_count !== 3'd4) begin fails++; $display("FAIL fill4_word_count got %0d exp 4", bus.word_count); end
      send_frame(32'hE0E0_0005, 1'b0);
      tick();
      checks++; if (bus.word_count !== 3'd4) begin fails++; $display("FAIL fill5_word_count got %0d exp 4", bus.word_count); end
      checks++; if (wr_pulses - p0 !== 4) begin fails++; $display("FAIL fill_pulses got %0d exp 4", wr_pulses - p0); end
      read_addr(2'd3, rd);
      checks++; if (rd !== 32'hD0D0_0004) begin fails++; $display("FAIL fill_mem3 got %h exp d0d00004", rd); end
      read_addr(2'd0, rd);
      checks++; if (rd !== 32'hA0A0_0001) begin fails++; $display("FAIL fill_mem0 got %h exp a0a00001", rd); end
   endtask

   task automatic test_load_start();
      bus.load_start  = 1'b1;
      bus.instr_in_en = 1'b1;
      bus.instr_in    = 1'b1;
      tick();
      bus.load_start  = 1'b0;
      bus.instr_in_en = 1'b0;
      checks++; if (bus.word_count !== 3'd0) begin fails++; $display("FAIL restart_word_count got %0d exp 0", bus.word_count); end
      checks++; if (bus.load_done !== 1'b0) begin fails++; $display("FAIL restart_load_done got %b exp 0", bus.load_done); end
      bus.rd_addr = 2'd0;
      send_frame(32'hDEAD_BEEF, 1'b0);
      checks++; if (bus.instr_out !== 32'hA0A0_0001) begin fails++; $display("FAIL restart_old_read got %h exp a0a00001", bus.instr_out); end
      tick();
      checks++; if (bus.instr_out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL restart_mem0 got %h exp deadbeef", bus.instr_out); end
      checks++; if (bus.word_count !== 3'd1) begin fails++; $display("FAIL restart_count got %0d exp 1", bus.word_count); end
      read_addr(2'd1, rd);
      checks++; if (rd !== 32'hB0B0_0002) begin fails++; $display("FAIL restart_mem1_kept got %h exp b0b00002", rd); end
   endtask

   task automatic test_parity();
`ifdef PARITY_CHECK_EN
      restart();
      p0 = wr_pulses;
      send_frame(32'h0000_0001, 1'b1);
      checks++; if (bus.parity_err !== 1'b1) begin fails++; $display("FAIL parity_err_set got %b exp 1", bus.parity_err); end
      checks++; if (bus.word_count !== 3'd0) begin fails++; $display("FAIL parity_bad_count got %0d exp 0", bus.word_count); end
      tick();
      checks++; if (wr_pulses - p0 !== 0) begin fails++; $display("FAIL parity_bad_pulses got %0d exp 0", wr_pulses - p0); end
      send_frame(32'h1357_9BDF, 1'b0);
      checks++; if (bus.word_count !== 3'd1) begin fails++; $display("FAIL parity_good_count got %0d exp 1", bus.word_count); end
      checks++; if (bus.parity_err !== 1'b1) begin fails++; $display("FAIL parity_err_sticky got %b exp 1", bus.parity_err); end
      read_addr(2'd0, rd);
      checks++; if (rd !== 32'h1357_9BDF) begin fails++; $display("FAIL parity_good_mem0 got %h exp 13579bdf", rd); end
`else
      checks++; if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL parity_tied got %b exp 0", bus.parity_err); end
`endif
   endtask

   initial begin
      checks          = 0;
      fails           = 0;
      wr_pulses       = 0;
      rst_n           = 1'b0;
      bus.load_start  = 1'b0;
      bus.instr_in    = 1'b0;
      bus.instr_in_en = 1'b0;
      bus.rd_addr     = 2'd0;
      test_reset();
      test_single_word();
      test_gap();
      test_reset_mid_frame();
      test_fill();
      test_load_start();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
